// File: rtl/button_event_decoder_pkg.sv
// -----------------------------------------------------------------------------
// button_event_pkg
// Shared definitions for the button event decoder:
//   - 3-bit state encodings and the FSM state type
//   - default timing constants for the 50 MHz cape clock
// -----------------------------------------------------------------------------
package button_event_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        PRESS1 = ST_PRESS1,
        GAP    = ST_GAP,
        PRESS2 = ST_PRESS2,
        LONG   = ST_LONG
    } state_t;

    // 0.5 s hold and 0.25 s double-click window at 50 MHz
    localparam int DEF_CNT_W         = 25;
    localparam int DEF_LONG_CYCLES   = 25_000_000;
    localparam int DEF_DCLICK_CYCLES = 12_500_000;

endpackage

// File: rtl/button_event_decoder_if.sv
// -----------------------------------------------------------------------------
// button_event_if
// Bundles the debounced button level and the decoded event pulses.
//   btn_in        : debounced switch level (from the debounce stage)
//   held          : registered pressed level
//   press_pulse   : one-cycle pulse on press edge
//   release_pulse : one-cycle pulse on release edge
//   single_click  : one-cycle pulse, click without a second press in window
//   double_click  : one-cycle pulse, second click completed inside window
//   long_press    : one-cycle pulse when the hold reaches the long threshold
// master = producer of btn_in / consumer of events; slave = the decoder.
// -----------------------------------------------------------------------------
interface button_event_if;
    import button_event_pkg::*;

    logic btn_in;
    logic held;
    logic press_pulse;
    logic release_pulse;
    logic single_click;
    logic double_click;
    logic long_press;

    modport master (
        output btn_in,
        input  held, press_pulse, release_pulse,
        input  single_click, double_click, long_press
    );

    modport slave (
        input  btn_in,
        output held, press_pulse, release_pulse,
        output single_click, double_click, long_press
    );

endinterface

// File: rtl/button_event_decoder_edge_detect.sv
// -----------------------------------------------------------------------------
// button_edge_detect
// Applies button polarity and keeps the previous pressed level (btn_q).
//   clk, resetn : clock, asynchronous active-low reset
//   i_level     : debounced raw button level
//   o_held      : registered pressed level (btn_q)
//   o_rise      : combinational press condition (p=1, btn_q=0)
//   o_fall      : combinational release condition (p=0, btn_q=1)
// Rise/fall are left combinational so the FSM in the top can act on the same
// edge that updates btn_q; the top registers them into the output pulses.
// -----------------------------------------------------------------------------
module button_edge_detect
    import button_event_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_level,
    output logic o_held,
    output logic o_rise,
    output logic o_fall
);

    logic w_p;
    logic r_btn_q;

    assign w_p = i_level ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_btn_q <= 1'b0;
        end else begin
            r_btn_q <= w_p;
        end
    end

    assign o_held = r_btn_q;
    assign o_rise = w_p & ~r_btn_q;
    assign o_fall = ~w_p & r_btn_q;

endmodule

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
// Turns the debounced button level into single-cycle event pulses:
// press/release edges, single click, double click and long press.
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : button_event_if.slave (btn_in in, event pulses out)
// One shared counter times both the hold (PRESS1/PRESS2) and the released gap
// (GAP). It is cleared on every state change and compared for equality.
// -----------------------------------------------------------------------------
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int DCLICK_CYCLES = DEF_DCLICK_CYCLES
) (
    input  logic           clk,
    input  logic           resetn,
    button_event_if.slave  bus
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

    logic             w_held;
    logic             w_rise;
    logic             w_fall;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_single;
    logic             w_double;
    logic             w_long;

    logic             r_press_pulse;
    logic             r_release_pulse;
    logic             r_single_click;
    logic             r_double_click;
    logic             r_long_press;

    button_edge_detect #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_edge (
        .clk     (clk),
        .resetn  (resetn),
        .i_level (bus.btn_in),
        .o_held  (w_held),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_single_click  <= 1'b0;
            r_double_click  <= 1'b0;
            r_long_press    <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_press_pulse   <= w_rise;
            r_release_pulse <= w_fall;
            r_single_click  <= w_single;
            r_double_click  <= w_double;
            r_long_press    <= w_long;
        end
    end

    // Edge conditions are tested before the timeouts, so a release beats the
    // long threshold and a press beats the gap timeout on the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_single     = 1'b0;
        w_double     = 1'b0;
        w_long       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_next = PRESS1;
                    w_cnt_next   = '0;
                end
            end
            PRESS1: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_fall) begin
                    w_state_next = GAP;
                    w_cnt_next   = '0;
                end else if (r_cnt == LONG_LAST) begin
                    w_long       = 1'b1;
                    w_state_next = LONG;
                    w_cnt_next   = '0;
                end
            end
            GAP: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_rise) begin
                    w_state_next = PRESS2;
                    w_cnt_next   = '0;
                end else if (r_cnt == DCLICK_LAST) begin
                    w_single     = 1'b1;
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            end
            PRESS2: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_fall) begin
                    w_double     = 1'b1;
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == LONG_LAST) begin
                    // A long second press discards the pending first click.
                    w_long       = 1'b1;
                    w_state_next = LONG;
                    w_cnt_next   = '0;
                end
            end
            LONG: begin
                if (w_fall) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign bus.held          = w_held;
    assign bus.press_pulse   = r_press_pulse;
    assign bus.release_pulse = r_release_pulse;
    assign bus.single_click  = r_single_click;
    assign bus.double_click  = r_double_click;
    assign bus.long_press    = r_long_press;

endmodule
